if_prefetch_queue: RTL
======================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end for the RV32 pipeline. Replaces the combinational PC->ROM
//  path with a request/response instruction-memory port that tolerates variable latency, and buffers
//  prefetched {PC, instruction} pairs in a DEPTH-entry FIFO feeding the IF/ID register.
//  Branch/JALR redirects from ID flush the queue and discard in-flight responses.
// PARAMETERS
//  XLEN      32   data/address width
//  DEPTH     4    FIFO entries, power of 2, >=2; also the maximum number of outstanding requests
//  RESET_PC  0    fetch address after reset
// PORTS
//  clk            in   1     main (debug) clock, rising edge
//  rst            in   1     asynchronous reset, active high
//  imem_req       out  1     request valid
//  imem_addr      out  XLEN  request byte address, bits[1:0]=0
//  imem_gnt       in   1     request accepted this cycle (handshake imem_req&&imem_gnt)
//  imem_rvalid    in   1     in-order response valid
//  imem_rdata     in   XLEN  response instruction
//  redirect_valid in   1     flush and restart fetch (Branch taken in ID)
//  redirect_pc    in   XLEN  new fetch PC; bits[1:0] ignored (forced 0)
//  inst_valid     out  1     head entry valid toward ID
//  inst           out  XLEN  head instruction
//  inst_pc        out  XLEN  head PC
//  id_ready       in   1     ID accepts head (low = pipeline stall); pop = inst_valid&&id_ready
// BEHAVIOUR
//  - Reset: fetch_pc=resp_pc=RESET_PC, count=0, outstanding=0, discard=0, imem_req=0, inst_valid=0,
//    inst=0, inst_pc=0. Reset asserted mid-operation clears all state immediately; later responses are
//    not tracked (the memory is reset with the core).
//  - Issue: imem_req = !redirect_valid && (count + outstanding < DEPTH); imem_addr = fetch_pc.
//    On grant: fetch_pc += 4 (wraps modulo 2^XLEN), outstanding += 1.
//  - Response: outstanding -= 1 on every imem_rvalid. If discard>0: drop, discard -= 1. Otherwise push
//    {resp_pc, imem_rdata} and advance resp_pc += 4. Responses return strictly in request order.
//  - Latency: a response pushed at edge N is presented on inst/inst_valid after edge N (one cycle of
//    register latency minimum); no bypass around the FIFO.
//  - Credit rule guarantees no push while full; a push and a pop in the same cycle leave count unchanged.
//    imem_rvalid with outstanding==0 is a protocol error: ignored, and flagged by a bench assertion.
//  - Redirect (highest priority): in that cycle imem_req=0 and inst_valid is forced to 0 (no pop). At the
//    edge: FIFO emptied, fetch_pc=resp_pc={redirect_pc[XLEN-1:2],2'b00}, any response arriving that
//    cycle is dropped, discard = outstanding - imem_rvalid. Back-to-back redirects: the last one wins,
//    and discard keeps covering every in-flight response.
//  - Empty: inst_valid=0; inst/inst_pc hold their last values.
// CONFIGURATION
//  - IFQ_STATS_EN defined: adds outputs stat_flush[31:0] (redirects taken) and stat_starve[31:0]
//    (cycles with id_ready=1 && inst_valid=0 && !redirect_valid). Both are saturating, reset to 0 and
//    readable through CPUTEST.
//  - IFQ_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 Reset, memory with gnt=1 and 1-cycle rvalid, id_ready=1 -> inst_pc sequence 0,4,8,... one per cycle
//    after fill; imem_req never pending with 4 entries in use.
//  2 id_ready=0 for 10 cycles -> count saturates at DEPTH=4; exactly 4 grants; imem_req=0; entries
//    0,4,8,C retained in order on release.
//  3 3-cycle response latency, 2 outstanding, redirect_pc=0x40 -> the next 2 rvalids are dropped; the
//    first inst_pc out is 0x40.
//  4 Redirect in the same cycle as rvalid and a full FIFO -> FIFO empty, inst_valid=0 next cycle,
//    discard = outstanding-1, no stray PC.
//  5 redirect_pc=0xFFFFFFFE -> imem_addr=0xFFFFFFFC, then 0x00000000 (wrap); inst_pc matches.
//  6 IFQ_STATS_EN: 3 redirects plus 5 starved cycles -> stat_flush=3, stat_starve=5; rst clears both.

Source files
------------

// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
//
// Instruction-fetch front end for the RV32 pipeline. Issues requests on a
// request/grant/in-order-response instruction-memory port and buffers the
// returned {PC, instruction} pairs in a DEPTH-entry FIFO that feeds IF/ID.
// A redirect from ID empties the FIFO, restarts fetch at the new PC and
// discards every response still in flight.
//
// Parameters
//   XLEN      data/address width
//   DEPTH     FIFO entries (power of 2, >= 2); also the outstanding-request cap
//   RESET_PC  fetch address after reset
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req/imem_addr/imem_gnt  request channel (handshake req && gnt)
//   imem_rvalid/imem_rdata       in-order response channel
//   redirect_valid/redirect_pc   flush and restart fetch
//   inst_valid/inst/inst_pc      FIFO head toward ID
//   id_ready                     ID accepts the head this cycle
//
// Optional feature (macro IFQ_STATS_EN)
//   stat_flush   saturating count of redirects taken
//   stat_starve  saturating count of cycles with id_ready && !inst_valid
//                && !redirect_valid
// -----------------------------------------------------------------------------
module if_prefetch_queue #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            id_ready
`ifdef IFQ_STATS_EN
  ,
  output logic [31:0]     stat_flush,
  output logic [31:0]     stat_starve
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // Architectural state
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             req_q, req_d;
  logic [XLEN-1:0]  inst_q, inst_d;
  logic [XLEN-1:0]  inst_pc_q, inst_pc_d;

  // FIFO storage
  logic [XLEN-1:0]  mem_inst [DEPTH];
  logic [XLEN-1:0]  mem_pc   [DEPTH];

  logic             grant;
  logic             rsp;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   credit_used;

  // Credit is evaluated on next-state values and registered, so the request
  // is low while reset is held; a redirect still kills it combinationally.
  assign imem_req   = req_q && !redirect_valid;
  assign imem_addr  = fetch_pc_q;
  assign inst_valid = (count_q != '0) && !redirect_valid;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  assign grant = imem_req && imem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp   = imem_rvalid && (outstanding_q != '0);
  assign push  = rsp && !redirect_valid && (discard_q == '0);
  assign pop   = inst_valid && id_ready;

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    credit_used   = '0;

    if (redirect_valid) begin
      // imem_req is low, so no grant this cycle; a response arriving now is
      // dropped and every other in-flight response must be discarded too.
      fetch_pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      resp_pc_d     = {redirect_pc[XLEN-1:2], 2'b00};
      count_d       = '0;
      rd_ptr_d      = wr_ptr_q;
      outstanding_d = outstanding_q - CNT_W'(rsp);
      discard_d     = outstanding_q - CNT_W'(rsp);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp);

      if (rsp && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end

      if (push) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // Head registers: when the FIFO is (or becomes) empty the new head can
      // only be the entry pushed now; otherwise popping exposes the next
      // stored entry. With nothing to show, the last values are held.
      if ((count_q == '0) || (pop && (count_q == CNT_W'(1)))) begin
        if (push) begin
          inst_d    = imem_rdata;
          inst_pc_d = resp_pc_q;
        end
      end else if (pop) begin
        inst_d    = mem_inst[rd_ptr_q + PTR_W'(1)];
        inst_pc_d = mem_pc[rd_ptr_q + PTR_W'(1)];
      end
    end

    credit_used = {1'b0, count_d} + {1'b0, outstanding_d};
    req_d       = credit_used < (CNT_W+1)'(DEPTH);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      req_q         <= 1'b0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      req_q         <= req_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]   <= resp_pc_q;
    end
  end

`ifdef IFQ_STATS_EN
  logic [31:0] stat_flush_q, stat_flush_d;
  logic [31:0] stat_starve_q, stat_starve_d;

  always_comb begin
    stat_flush_d  = stat_flush_q;
    stat_starve_d = stat_starve_q;
    if (redirect_valid && (stat_flush_q != '1)) begin
      stat_flush_d = stat_flush_q + 32'd1;
    end
    if (id_ready && !inst_valid && !redirect_valid && (stat_starve_q != '1)) begin
      stat_starve_d = stat_starve_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flush_q  <= '0;
      stat_starve_q <= '0;
    end else begin
      stat_flush_q  <= stat_flush_d;
      stat_starve_q <= stat_starve_d;
    end
  end

  assign stat_flush  = stat_flush_q;
  assign stat_starve = stat_starve_q;
`endif

endmodule
